i2s_capture_ctrl: RTL and testbench

- Sequencer in front of the I2S microphone master's sample stream.
- On a start command it enables the I2S master and discards a programmable number of warm-up samples, covering the mic start-up settling period.
- It then captures a programmable burst of 24-bit samples into an internal FIFO and presents them downstream on a valid/ready interface.
- Sits between i2s_master and the downstream DSP/UART consumer; owns the master's enable.

---
 rtl/i2s_capture_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture_ctrl.sv
// Capture sequencer for the I2S microphone stream: enables the master, discards
// warm-up samples, buffers a burst in a FIFO and hands it downstream on valid/ready.
module i2s_capture_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CNT_W-1:0]              cfg_warmup,
    input  logic [CNT_W-1:0]              cfg_burst_len,
    output logic                          i2s_en,
    input  logic [23:0]                   sample_data,
    input  logic                          sample_valid,
    output logic [23:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] warmup_r;
    logic [CNT_W-1:0] burst_len_r;
    logic [CNT_W-1:0] warm_cnt_r;
    logic [CNT_W-1:0] burst_cnt_r;
    logic [CNT_W-1:0] warm_cnt_nxt_s;
    logic [CNT_W-1:0] burst_cnt_nxt_s;
    logic             i2s_en_r;
    logic             busy_r;
    logic             done_r;
    logic             overflow_r;

    logic [23:0]      mem_r [FIFO_DEPTH];
    logic [LW-1:0]    wr_ptr_r;
    logic [LW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_s;
    logic             empty_s;
    logic             full_s;
    logic             flush_s;
    logic             push_s;
    logic             pop_s;
    logic             write_s;
    logic             drop_s;
    logic [23:0]      out_data_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // FIFO status, push/pop qualification and saturating counter increments
    always_comb begin
        level_s         = wr_ptr_r - rd_ptr_r;
        empty_s         = (level_s == {LW{1'b0}});
        full_s          = (level_s == LW'(FIFO_DEPTH));
        flush_s         = abort && (state_r != IDLE);
        push_s          = (state_r == CAPTURE) && sample_valid && !abort;
        pop_s           = !empty_s && out_ready && !flush_s;
        // a full FIFO still accepts the sample when the head leaves on the same edge
        write_s         = push_s && (!full_s || pop_s);
        drop_s          = push_s && full_s && !pop_s;
        warm_cnt_nxt_s  = sat_inc(warm_cnt_r);
        burst_cnt_nxt_s = sat_inc(burst_cnt_r);
    end

    // First-word fall-through head; forced to zero while empty so no stale data leaks
    always_comb begin
        if (empty_s) begin
            out_data_s = 24'd0;
        end else begin
            out_data_s = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    assign out_data   = out_data_s;
    assign out_valid  = !empty_s;
    assign fifo_level = level_s;
    assign i2s_en     = i2s_en_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign overflow   = overflow_r;

    // Sample storage
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= sample_data;
        end
    end

    // FIFO pointers with extra wrap bit; abort flushes the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {LW{1'b0}};
            rd_ptr_r <= {LW{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {LW{1'b0}};
            rd_ptr_r <= {LW{1'b0}};
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + LW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + LW'(1);
            end
        end
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

    // Sequencer FSM with registered enable, busy and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            warmup_r    <= {CNT_W{1'b0}};
            burst_len_r <= {CNT_W{1'b0}};
            warm_cnt_r  <= {CNT_W{1'b0}};
            burst_cnt_r <= {CNT_W{1'b0}};
            i2s_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (flush_s) begin
                state_r  <= IDLE;
                i2s_en_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && !abort) begin
                            warmup_r    <= cfg_warmup;
                            burst_len_r <= cfg_burst_len;
                            warm_cnt_r  <= {CNT_W{1'b0}};
                            burst_cnt_r <= {CNT_W{1'b0}};
                            i2s_en_r    <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= (cfg_warmup == {CNT_W{1'b0}}) ? CAPTURE : WARMUP;
                        end
                    end
                    WARMUP: begin
                        if (sample_valid) begin
                            warm_cnt_r <= warm_cnt_nxt_s;
                            if (warm_cnt_nxt_s == warmup_r) begin
                                state_r <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (sample_valid) begin
                            burst_cnt_r <= burst_cnt_nxt_s;
                            if ((burst_len_r != {CNT_W{1'b0}}) && (burst_cnt_nxt_s == burst_len_r)) begin
                                state_r  <= DRAIN;
                                i2s_en_r <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (empty_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        i2s_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed self-checking bench for i2s_capture_ctrl (FIFO_DEPTH=16, CNT_W=16).
module tb_i2s_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] cfg_warmup;
    logic [15:0] cfg_burst_len;
    logic        i2s_en;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        overflow_clr;
    logic [4:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    i2s_capture_ctrl #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_warmup   (cfg_warmup),
        .cfg_burst_len(cfg_burst_len),
        .i2s_en       (i2s_en),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [23:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] wu, input logic [15:0] bl);
        cfg_warmup    = wu;
        cfg_burst_len = bl;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i2s_en"}, {31'd0, i2s_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_level"}, {27'd0, fifo_level}, 32'd0);
        chk({tag, "_out_data"}, {8'd0, out_data}, 32'd0);
    endtask

    initial begin
        logic [23:0] d;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        cfg_warmup    = 16'd0;
        cfg_burst_len = 16'd0;
        sample_data   = 24'd0;
        sample_valid  = 1'b0;
        out_ready     = 1'b0;
        overflow_clr  = 1'b0;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Warm-up discard: 3 dropped, 4 captured, consumer always ready
        out_ready = 1'b1;
        do_start(16'd3, 16'd4);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_en", {31'd0, i2s_en}, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            d = 24'(i);
            strobe(d);
            if (i <= 3) begin
                chk("t1_warm_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("t1_valid", {31'd0, out_valid}, 32'd1);
                chk("t1_data", {8'd0, out_data}, 32'(i));
            end
            if (i == 6) chk("t1_en_mid", {31'd0, i2s_en}, 32'd1);
            if (i == 7) chk("t1_en_off", {31'd0, i2s_en}, 32'd0);
            tick();
        end
        chk("t1_drain_done", {31'd0, done}, 32'd0);
        chk("t1_drain_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy_fall", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_done_once", {31'd0, done}, 32'd0);

        // Overflow: burst of 20 into a 16-deep FIFO with consumer stalled
        out_ready = 1'b0;
        do_start(16'd0, 16'd20);
        for (int i = 0; i < 20; i++) begin
            d = 24'(100 + i);
            strobe(d);
            if (i == 15) begin
                chk("t2_full_level", {27'd0, fifo_level}, 32'd16);
                chk("t2_no_ovf_yet", {31'd0, overflow}, 32'd0);
            end
            if (i == 16) begin
                chk("t2_sat_level", {27'd0, fifo_level}, 32'd16);
                chk("t2_ovf", {31'd0, overflow}, 32'd1);
            end
            tick();
        end
        chk("t2_en_off", {31'd0, i2s_en}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t2_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_data", {8'd0, out_data}, 32'(100 + k));
            tick();
        end
        chk("t2_empty", {27'd0, fifo_level}, 32'd0);
        chk("t2_no_early_done", {31'd0, done}, 32'd0);
        tick();
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_ovf_sticky", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t2_ovf_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        do_start(16'd0, 16'd0);
        for (int i = 0; i < 16; i++) begin
            d = 24'(200 + i);
            strobe(d);
            tick();
        end
        chk("t3_full", {27'd0, fifo_level}, 32'd16);
        out_ready    = 1'b1;
        sample_data  = 24'hABCDEF;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        out_ready    = 1'b0;
        chk("t3_level_same", {27'd0, fifo_level}, 32'd16);
        chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
        chk("t3_head_adv", {8'd0, out_data}, 32'd201);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("t3_appended", {8'd0, out_data}, 32'h00ABCDEF);
            tick();
        end
        chk("t3_drained", {27'd0, fifo_level}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_busy", {31'd0, busy}, 32'd0);
        chk("t3_abort_done", {31'd0, done}, 32'd0);

        // Abort mid-capture after warm-up of 2 and 5 buffered samples
        out_ready = 1'b0;
        do_start(16'd2, 16'd0);
        strobe(24'h000050);
        tick();
        strobe(24'h000051);
        tick();
        for (int i = 0; i < 5; i++) begin
            d = 24'(96 + i);
            strobe(d);
            tick();
        end
        chk("t4_level5", {27'd0, fifo_level}, 32'd5);
        chk("t4_head", {8'd0, out_data}, 32'h60);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_level", {27'd0, fifo_level}, 32'd0);
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_en", {31'd0, i2s_en}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_done", {31'd0, done}, 32'd0);
        tick();
        chk("t4_done_later", {31'd0, done}, 32'd0);

        // warmup=0, burst=1, start held for three cycles
        cfg_warmup    = 16'd0;
        cfg_burst_len = 16'd1;
        start         = 1'b1;
        tick();
        chk("t6_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        start = 1'b0;
        chk("t6_en_held", {31'd0, i2s_en}, 32'd1);
        chk("t6_level0", {27'd0, fifo_level}, 32'd0);
        strobe(24'h123456);
        chk("t6_en_off", {31'd0, i2s_en}, 32'd0);
        chk("t6_level1", {27'd0, fifo_level}, 32'd1);
        chk("t6_data", {8'd0, out_data}, 32'h00123456);
        out_ready = 1'b1;
        tick();
        chk("t6_popped", {27'd0, fifo_level}, 32'd0);
        chk("t6_not_done", {31'd0, done}, 32'd0);
        tick();
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_busy_fall", {31'd0, busy}, 32'd0);
        out_ready = 1'b0;
        tick();
        chk("t6_done_once", {31'd0, done}, 32'd0);
        chk("t6_one_burst", {31'd0, busy}, 32'd0);

        // Asynchronous reset in CAPTURE with six samples buffered
        do_start(16'd0, 16'd0);
        for (int i = 0; i < 6; i++) begin
            d = 24'(48 + i);
            strobe(d);
            tick();
        end
        chk("t5_level6", {27'd0, fifo_level}, 32'd6);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        #10;
        rst_n = 1'b1;
        tick();
        chk("t5_idle_after", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
